// File: rtl/seq_pkg.sv
// Shared definitions for the LEGv8 multi-cycle datapath sequencer.
//   seq_state_t     : sequencer state encoding
//   TIMEOUT_DEFAULT : default RAM acknowledge limit in cycles (legal range 1..255)
package seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_HALTED = ST_HALTED,
    S_FAULT  = ST_FAULT
  } seq_state_t;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_watchdog.sv
// RAM handshake watchdog.
//   clock   : system clock, rising edge
//   reset   : asynchronous active-low reset
//   active  : request outstanding without acknowledge this cycle
//   clear   : restart the count (ack seen or sequencer changing state)
//   expired : this is the TIMEOUT-th waiting cycle and no ack arrived
module mem_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  // count_q holds the number of waiting cycles already elapsed, so the
  // TIMEOUT-th cycle is the one where count_q == TIMEOUT-1.
  assign expired = active && (count_q == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (active && (count_q != LAST)) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer between the LEGv8 decoder and the shared RAM port.
// Steps each instruction through FETCH, EXEC and optional MEM, turns the
// decoder enables into single-cycle strobes, guards RAM accesses with a
// watchdog and counts retired instructions.
//   clock, reset          : clock and asynchronous active-low reset
//   halt_req              : stop at the next instruction boundary
//   cw_ns/en_ram/wm/wr/en_pc : decoder control-word bits
//   mem_ack               : RAM completion (only meaningful while mem_req)
//   mem_req/mem_we/mem_sel: RAM request, write enable, address select
//   ir_load/pc_load/rf_we : write strobes (combinational)
//   cu_state              : registered phase bit for two-phase instructions
//   busy/fault            : status, decoded from the state register
//   instr_count           : retired-instruction counter (wraps)
//
// state  | meaning
// IDLE   | first cycle after reset, nothing driven
// FETCH  | reading instruction at PC, waits for mem_ack
// EXEC   | execute phase; may repeat once for two-phase instructions
// MEM    | data access at ALU result, waits for mem_ack
// HALTED | parked at an instruction boundary until halt_req drops
// FAULT  | timeout or illegal phase sequence; left only by reset
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt_req,
  input  logic        cw_ns,
  input  logic        cw_en_ram,
  input  logic        cw_wm,
  input  logic        cw_wr,
  input  logic        cw_en_pc,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_load,
  output logic        pc_load,
  output logic        rf_we,
  output logic        cu_state,
  output logic        busy,
  output logic        fault,
  output logic [31:0] instr_count
);

  seq_state_t  state_q, state_d;
  logic        cu_q, cu_d;
  logic [31:0] count_q;
  logic        retire;
  logic        wd_expired;

  assign mem_req     = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_sel     = (state_q == S_MEM);
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
  assign fault       = (state_q == S_FAULT);
  assign cu_state    = cu_q;
  assign instr_count = count_q;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .active  (mem_req && !mem_ack),
    .clear   (mem_ack || (state_d != state_q)),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    cu_d    = cu_q;
    ir_load = 1'b0;
    pc_load = 1'b0;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = S_EXEC;
        end else if (wd_expired) begin
          state_d = S_FAULT;
        end
      end
      S_EXEC: begin
        if (cw_en_ram) begin
          state_d = S_MEM;
        end else if (cw_ns && !cu_q) begin
          rf_we = cw_wr;
          cu_d  = 1'b1;
        end else if (cw_ns && cu_q) begin
          // a second phase asking for a third is not a legal instruction
          state_d = S_FAULT;
        end else begin
          rf_we   = cw_wr;
          pc_load = cw_en_pc;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        mem_we = cw_wm;
        if (mem_ack) begin
          rf_we   = cw_wr;
          pc_load = cw_en_pc;
          retire  = 1'b1;
        end else if (wd_expired) begin
          state_d = S_FAULT;
        end
      end
      S_HALTED: begin
        if (!halt_req) state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (retire) begin
      cu_d    = 1'b0;
      state_d = halt_req ? S_HALTED : S_FETCH;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cu_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cu_q    <= cu_d;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle sequencer for the LEGv8 datapath. It sits between the instruction decoder and the single shared RAM port. It steps each instruction through fetch, execute and optional data-memory phases, and drives the one-bit state input that the decoder uses for two-phase instructions (e.g. MOVK). It converts the decoder's control-word enables into single-cycle write strobes, supervises the RAM request/acknowledge handshake with a watchdog, and counts retired instructions.

## Interface
- TIMEOUT, 15: maximum cycles a RAM request may wait for `mem_ack`; range 1–255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- halt_req  in  1  request to stop at the next instruction boundary.
- cw_ns  in  1  decoder NS bit: the instruction needs a second execute phase.
- cw_en_ram  in  1  decoder EN_RAM: the instruction accesses data memory.
- cw_wm  in  1  decoder WM: data access is a write.
- cw_wr  in  1  decoder WR: the register file is written.
- cw_en_pc  in  1  decoder EN_PC: the PC updates at retire.
- mem_ack  in  1  RAM completion, valid only while `mem_req`=1.
- mem_req  out  1  RAM request.
- mem_we  out  1  RAM write enable.
- mem_sel  out  1  address select: 0 = PC (fetch), 1 = ALU result (data).
- ir_load  out  1  instruction register load strobe.
- pc_load  out  1  PC update strobe.
- rf_we  out  1  register file write strobe.
- cu_state  out  1  phase bit fed to the decoder's state input.
- busy  out  1  high in FETCH, EXEC and MEM.
- fault  out  1  sticky error flag.
- instr_count  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALTED, FAULT.
- Reset values: state=IDLE, cu_state=0, instr_count=0, watchdog=0, fault=0. All strobes, `mem_req` and `busy` are 0 during reset.
- IDLE: no outputs active; goes to FETCH on the next edge.
- FETCH: drives mem_req=1, mem_sel=0, mem_we=0.
  - On mem_ack: ir_load=1 in the same cycle; next state is EXEC.
- EXEC, when cw_en_ram=1: no strobes; next state is MEM.
- EXEC, when cw_ns=1 and cu_state=0:
  - rf_we=cw_wr, pc_load=0.
  - cu_state is set to 1; state stays in EXEC.
- EXEC, when cw_ns=1 and cu_state=1: next state is FAULT; all strobes are suppressed.
- EXEC, all other cases: this is a retire.
  - rf_we=cw_wr, pc_load=cw_en_pc.
  - cu_state is cleared.
- MEM: drives mem_req=1, mem_sel=1, mem_we=cw_wm.
  - On mem_ack: rf_we=cw_wr (load data), pc_load=cw_en_pc; this is a retire.
- Retire: instr_count increments, wrapping from FFFF_FFFF to 0.
  - halt_req is sampled in the retire cycle: 1 goes to HALTED, 0 goes to FETCH.
- HALTED: no outputs active; returns to FETCH in the cycle after halt_req=0.
- FAULT: fault=1 and all strobes are 0. The only exit is reset.
- Watchdog counter:
  - Increments each cycle that mem_req=1 and mem_ack=0.
  - Clears on mem_ack or on any state change.
  - An ack in the TIMEOUT-th cycle of a request is accepted.
  - If there is no ack by the end of that cycle, the next state is FAULT.
- Ignored inputs:
  - mem_ack outside FETCH/MEM.
  - halt_req outside retire cycles.
  - cw_* outside EXEC/MEM.

## Timing
- mem_req, mem_sel, busy and fault are Moore outputs (decoded from the registered state).
- ir_load, pc_load, rf_we and mem_we are Mealy outputs, combinational from state and inputs.
- cu_state is registered.
- Zero-wait RAM: an ALU instruction takes 2 cycles, a load/store 3, and a two-phase instruction 3.
- Each RAM wait cycle adds one cycle.
- Reset asserted mid-access drops mem_req immediately (asynchronous); no strobe fires.
- Ack and halt_req arriving in the same MEM cycle: the instruction retires, then the sequencer halts.

## Structure
- Package `seq_pkg`: state encoding localparams and the default for TIMEOUT.
- Sub-module `mem_watchdog`: parameter TIMEOUT.
  - Inputs: clock, reset, active (mem_req & ~mem_ack), clear.
  - Output: expired.
  - Counter width: $clog2(TIMEOUT+1).

## Test plan
- Release reset with ack tied high: IDLE lasts 1 cycle; FETCH has ir_load=1; EXEC (cw_wr=1, cw_en_pc=1) has rf_we=pc_load=1; instr_count=1 after 3 cycles.
- Load (cw_en_ram=1, cw_wm=0, cw_wr=1) with ack after 2 wait cycles: MEM holds mem_req=1 and mem_sel=1 for 3 cycles; rf_we pulses once, on the ack cycle.
- Two-phase instruction (cw_ns=1, then 0): cu_state=1 for exactly one cycle; pc_load is asserted only in the second EXEC cycle; instr_count increments by 1.
- TIMEOUT=4, no ack in FETCH: fault=1 after 4 request cycles and stays high; mem_req=0; only reset clears it.
- halt_req=1 during a store's ack cycle: the store completes with mem_we=1; the sequencer goes to HALTED; FETCH resumes one cycle after halt_req falls.
- Preload instr_count to FFFF_FFFF via forced retires: the next retire wraps it to 0.
